// File: rtl/edge_tile_scanner.sv
// edge_tile_scanner: walks a tile-aligned bounding box row-major, one TILE x TILE
// tile per cycle, and streams a per-pixel coverage mask (all edge equations >= 0)
// for each tile on a valid/ready interface. Empty tiles can optionally be skipped.
module edge_tile_scanner #(
  parameter int TILE       = 2,
  parameter int NUM_EDGES  = 3,
  parameter int W_WIDTH    = 32,
  parameter int DX_WIDTH   = 19,
  parameter int DY_WIDTH   = 24,
  parameter int COORD_W    = 8,
  parameter int SKIP_EMPTY = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_EDGES*W_WIDTH-1:0]  in_w,
  input  logic [NUM_EDGES*DX_WIDTH-1:0] in_dx,
  input  logic [NUM_EDGES*DY_WIDTH-1:0] in_dy,
  input  logic [COORD_W-1:0]            in_tiles_x,
  input  logic [COORD_W-1:0]            in_tiles_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_W-1:0]            out_tile_x,
  output logic [COORD_W-1:0]            out_tile_y,
  output logic [TILE*TILE-1:0]          out_mask,
  output logic                          out_last,
  output logic                          done,
  output logic                          busy
);

  localparam int MW = TILE * TILE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // primed_q is low during the first SCAN cycle, which is spent registering the
  // per-pixel offset table and tile steps so the evaluation path is a single add.
  logic primed_q, primed_d;

  logic [W_WIDTH-1:0] dx_q       [NUM_EDGES];
  logic [W_WIDTH-1:0] dx_d       [NUM_EDGES];
  logic [W_WIDTH-1:0] dy_q       [NUM_EDGES];
  logic [W_WIDTH-1:0] dy_d       [NUM_EDGES];
  logic [W_WIDTH-1:0] col_step_q [NUM_EDGES];
  logic [W_WIDTH-1:0] col_step_d [NUM_EDGES];
  logic [W_WIDTH-1:0] row_step_q [NUM_EDGES];
  logic [W_WIDTH-1:0] row_step_d [NUM_EDGES];
  logic [W_WIDTH-1:0] w_tile_q   [NUM_EDGES];
  logic [W_WIDTH-1:0] w_tile_d   [NUM_EDGES];
  logic [W_WIDTH-1:0] w_row_q    [NUM_EDGES];
  logic [W_WIDTH-1:0] w_row_d    [NUM_EDGES];
  logic [W_WIDTH-1:0] off_q      [NUM_EDGES][MW];
  logic [W_WIDTH-1:0] off_d      [NUM_EDGES][MW];

  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] tiles_x_q, tiles_x_d, tiles_y_q, tiles_y_d;
  logic [COORD_W-1:0] out_tile_x_q, out_tile_x_d, out_tile_y_q, out_tile_y_d;
  logic [MW-1:0]      out_mask_q, out_mask_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;

  // Sign-extended views of the setup inputs and the combinational coverage test.
  logic [W_WIDTH-1:0]   in_w_e  [NUM_EDGES];
  logic [W_WIDTH-1:0]   in_dx_e [NUM_EDGES];
  logic [W_WIDTH-1:0]   in_dy_e [NUM_EDGES];
  logic [NUM_EDGES-1:0] pix_ok  [MW];
  logic [MW-1:0]        mask_eval;

  logic tile_last;
  logic tile_emit;

  genvar gi, gp;
  generate
    for (gi = 0; gi < NUM_EDGES; gi++) begin : g_edge
      assign in_w_e[gi]  = in_w[gi*W_WIDTH +: W_WIDTH];
      assign in_dx_e[gi] = W_WIDTH'($signed(in_dx[gi*DX_WIDTH +: DX_WIDTH]));
      assign in_dy_e[gi] = W_WIDTH'($signed(in_dy[gi*DY_WIDTH +: DY_WIDTH]));
      for (gp = 0; gp < MW; gp++) begin : g_pix
        logic [W_WIDTH-1:0] pix_sum;
        assign pix_sum          = w_tile_q[gi] + off_q[gi][gp];
        assign pix_ok[gp][gi]   = ~pix_sum[W_WIDTH-1];
      end
    end
    for (gp = 0; gp < MW; gp++) begin : g_mask
      assign mask_eval[gp] = &pix_ok[gp];
    end
  endgenerate

  // Next-state logic: setup capture, tile evaluation/advance and output-stage control.
  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    col_step_d   = col_step_q;
    row_step_d   = row_step_q;
    w_tile_d     = w_tile_q;
    w_row_d      = w_row_q;
    off_d        = off_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    tiles_x_d    = tiles_x_q;
    tiles_y_d    = tiles_y_q;
    out_tile_x_d = out_tile_x_q;
    out_tile_y_d = out_tile_y_q;
    out_mask_d   = out_mask_q;
    out_last_d   = out_last_q;
    // A pending beat leaves the stage when the consumer takes it.
    out_valid_d  = out_valid_q && !out_ready;
    done_d       = 1'b0;
    tile_last    = (cx_q == tiles_x_q) && (cy_q == tiles_y_q);
    tile_emit    = !((SKIP_EMPTY != 0) && (mask_eval == '0));

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d   = S_SCAN;
          primed_d  = 1'b0;
          w_tile_d  = in_w_e;
          w_row_d   = in_w_e;
          dx_d      = in_dx_e;
          dy_d      = in_dy_e;
          cx_d      = '0;
          cy_d      = '0;
          tiles_x_d = in_tiles_x;
          tiles_y_d = in_tiles_y;
        end
      end

      S_SCAN: begin
        if (!primed_q) begin
          primed_d = 1'b1;
          for (int e = 0; e < NUM_EDGES; e++) begin
            col_step_d[e] = dx_q[e] * W_WIDTH'(TILE);
            row_step_d[e] = dy_q[e] * W_WIDTH'(TILE);
            for (int p = 0; p < MW; p++) begin
              off_d[e][p] = W_WIDTH'(p % TILE) * dx_q[e] + W_WIDTH'(p / TILE) * dy_q[e];
            end
          end
        end else if (!out_valid_q || out_ready) begin
          // Evaluation only happens when the stage is empty or draining this cycle,
          // so a skipped final tile never has an earlier beat left to tag as last.
          if (tile_emit) begin
            out_valid_d  = 1'b1;
            out_tile_x_d = cx_q;
            out_tile_y_d = cy_q;
            out_mask_d   = mask_eval;
            out_last_d   = tile_last;
          end
          if (cx_q < tiles_x_q) begin
            for (int e = 0; e < NUM_EDGES; e++) begin
              w_tile_d[e] = w_tile_q[e] + col_step_q[e];
            end
            cx_d = cx_q + COORD_W'(1);
          end else begin
            for (int e = 0; e < NUM_EDGES; e++) begin
              w_row_d[e]  = w_row_q[e] + row_step_q[e];
              w_tile_d[e] = w_row_q[e] + row_step_q[e];
            end
            cx_d = '0;
            cy_d = cy_q + COORD_W'(1);
          end
          if (tile_last) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          done_d      = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      primed_q     <= 1'b0;
      for (int e = 0; e < NUM_EDGES; e++) begin
        dx_q[e]       <= '0;
        dy_q[e]       <= '0;
        col_step_q[e] <= '0;
        row_step_q[e] <= '0;
        w_tile_q[e]   <= '0;
        w_row_q[e]    <= '0;
        for (int p = 0; p < MW; p++) begin
          off_q[e][p] <= '0;
        end
      end
      cx_q         <= '0;
      cy_q         <= '0;
      tiles_x_q    <= '0;
      tiles_y_q    <= '0;
      out_tile_x_q <= '0;
      out_tile_y_q <= '0;
      out_mask_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      col_step_q   <= col_step_d;
      row_step_q   <= row_step_d;
      w_tile_q     <= w_tile_d;
      w_row_q      <= w_row_d;
      off_q        <= off_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      tiles_x_q    <= tiles_x_d;
      tiles_y_q    <= tiles_y_d;
      out_tile_x_q <= out_tile_x_d;
      out_tile_y_q <= out_tile_y_d;
      out_mask_q   <= out_mask_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_tile_x = out_tile_x_q;
  assign out_tile_y = out_tile_y_q;
  assign out_mask   = out_mask_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_edge_tile_scanner.sv
// Directed bench for edge_tile_scanner: one instance without and one with empty-tile
// skipping share the same stimulus; accepted beats are logged and compared to tables.
module tb_edge_tile_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [95:0] in_w = '0;
  logic [56:0] in_dx = '0;
  logic [71:0] in_dy = '0;
  logic [7:0]  in_tiles_x = '0;
  logic [7:0]  in_tiles_y = '0;

  logic       in_ready_a, out_valid_a, out_last_a, done_a, busy_a;
  logic [7:0] out_tile_x_a, out_tile_y_a;
  logic [3:0] out_mask_a;
  logic       in_ready_b, out_valid_b, out_last_b, done_b, busy_b;
  logic [7:0] out_tile_x_b, out_tile_y_b;
  logic [3:0] out_mask_b;

  always #5 clk = ~clk;

  edge_tile_scanner #(.SKIP_EMPTY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_w(in_w), .in_dx(in_dx), .in_dy(in_dy),
    .in_tiles_x(in_tiles_x), .in_tiles_y(in_tiles_y),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_tile_x(out_tile_x_a), .out_tile_y(out_tile_y_a),
    .out_mask(out_mask_a), .out_last(out_last_a), .done(done_a), .busy(busy_a)
  );

  edge_tile_scanner #(.SKIP_EMPTY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_w(in_w), .in_dx(in_dx), .in_dy(in_dy),
    .in_tiles_x(in_tiles_x), .in_tiles_y(in_tiles_y),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_tile_x(out_tile_x_b), .out_tile_y(out_tile_y_b),
    .out_mask(out_mask_b), .out_last(out_last_b), .done(done_b), .busy(busy_b)
  );

  // Beat encoding {last, x, y, mask}
  typedef struct {
    logic [31:0]       w0;
    logic [18:0]       dx0;
    logic [23:0]       dy0;
    logic [7:0]        tx;
    logic [7:0]        ty;
    int                n0;
    int                n1;
    logic [3:0][20:0]  e0;
    logic [3:0][20:0]  e1;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] qa [$];
  logic [20:0] qb [$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  // Log every handshaken beat and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_a && out_ready) qa.push_back({out_last_a, out_tile_x_a, out_tile_y_a, out_mask_a});
      if (out_valid_b && out_ready) qb.push_back({out_last_b, out_tile_x_b, out_tile_y_b, out_mask_b});
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  function automatic logic [20:0] bt(input logic last, input logic [7:0] x,
                                     input logic [7:0] y, input logic [3:0] m);
    return {last, x, y, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v);
    int k;
    k = 0;
    while (!(in_ready_a && in_ready_b) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("launch_ready", {31'd0, in_ready_a && in_ready_b}, 32'd1);
    in_w       = {32'd5, 32'd5, v.w0};
    in_dx      = {19'd0, 19'd0, v.dx0};
    in_dy      = {24'd0, 24'd0, v.dy0};
    in_tiles_x = v.tx;
    in_tiles_y = v.ty;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic wait_done(input int da, input int db);
    int k;
    k = 0;
    while (!(done_cnt_a > da && done_cnt_b > db) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_a_count", done_cnt_a - da, 1);
    chk("done_b_count", done_cnt_b - db, 1);
  endtask

  task automatic check_stream(input string tag, input vec_t v, input int sa, input int sb);
    chk($sformatf("%s_beats_a", tag), qa.size() - sa, v.n0);
    for (int i = 0; i < v.n0 && sa + i < qa.size(); i++)
      chk($sformatf("%s_a_beat%0d", tag, i), {11'd0, qa[sa+i]}, {11'd0, v.e0[i]});
    chk($sformatf("%s_beats_b", tag), qb.size() - sb, v.n1);
    for (int i = 0; i < v.n1 && sb + i < qb.size(); i++)
      chk($sformatf("%s_b_beat%0d", tag, i), {11'd0, qb[sb+i]}, {11'd0, v.e1[i]});
  endtask

  task automatic run_vec(input int k);
    int sa, sb, da, db;
    sa = qa.size(); sb = qb.size(); da = done_cnt_a; db = done_cnt_b;
    launch(vecs[k]);
    wait_done(da, db);
    check_stream($sformatf("vec%0d", k), vecs[k], sa, sb);
    $display("vec %0d: beats noskip=%0d skip=%0d", k, qa.size() - sa, qb.size() - sb);
  endtask

  initial begin
    int sa, sb, da, db, k, na, nb;

    // all edges positive, single tile
    vecs[0] = '{w0: 32'd5, dx0: 19'd0, dy0: 24'd0, tx: 8'd0, ty: 8'd0, n0: 1, n1: 1, e0: '0, e1: '0};
    vecs[0].e0[0] = bt(1'b1, 8'd0, 8'd0, 4'hF);
    vecs[0].e1[0] = bt(1'b1, 8'd0, 8'd0, 4'hF);
    // x ramp across three tile columns, first tile empty
    vecs[1] = '{w0: 32'hFFFF_FFFE, dx0: 19'd1, dy0: 24'd0, tx: 8'd2, ty: 8'd0, n0: 3, n1: 2, e0: '0, e1: '0};
    vecs[1].e0[0] = bt(1'b0, 8'd0, 8'd0, 4'h0);
    vecs[1].e0[1] = bt(1'b0, 8'd1, 8'd0, 4'hF);
    vecs[1].e0[2] = bt(1'b1, 8'd2, 8'd0, 4'hF);
    vecs[1].e1[0] = bt(1'b0, 8'd1, 8'd0, 4'hF);
    vecs[1].e1[1] = bt(1'b1, 8'd2, 8'd0, 4'hF);
    // y ramp across two tile rows: row step is dy*TILE
    vecs[2] = '{w0: 32'hFFFF_FFFE, dx0: 19'd0, dy0: 24'd1, tx: 8'd0, ty: 8'd1, n0: 2, n1: 1, e0: '0, e1: '0};
    vecs[2].e0[0] = bt(1'b0, 8'd0, 8'd0, 4'h0);
    vecs[2].e0[1] = bt(1'b1, 8'd0, 8'd1, 4'hF);
    vecs[2].e1[0] = bt(1'b1, 8'd0, 8'd1, 4'hF);
    // positive max plus one wraps negative in column 1
    vecs[3] = '{w0: 32'h7FFF_FFFF, dx0: 19'd1, dy0: 24'd0, tx: 8'd0, ty: 8'd0, n0: 1, n1: 1, e0: '0, e1: '0};
    vecs[3].e0[0] = bt(1'b1, 8'd0, 8'd0, 4'b0101);
    vecs[3].e1[0] = bt(1'b1, 8'd0, 8'd0, 4'b0101);
    // every tile empty: skipping instance emits nothing but still signals done
    vecs[4] = '{w0: 32'hFFFF_FFFF, dx0: 19'd0, dy0: 24'd0, tx: 8'd1, ty: 8'd0, n0: 2, n1: 0, e0: '0, e1: '0};
    vecs[4].e0[0] = bt(1'b0, 8'd0, 8'd0, 4'h0);
    vecs[4].e0[1] = bt(1'b1, 8'd1, 8'd0, 4'h0);
    // final tile empty: skipping instance emits no last flag
    vecs[5] = '{w0: 32'd1, dx0: 19'h7FFFF, dy0: 24'd0, tx: 8'd1, ty: 8'd0, n0: 2, n1: 1, e0: '0, e1: '0};
    vecs[5].e0[0] = bt(1'b0, 8'd0, 8'd0, 4'hF);
    vecs[5].e0[1] = bt(1'b1, 8'd1, 8'd0, 4'h0);
    vecs[5].e1[0] = bt(1'b0, 8'd0, 8'd0, 4'hF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_a", {31'd0, in_ready_a}, 32'd1);
    chk("rst_out_valid_a", {31'd0, out_valid_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_last_mask_a", {27'd0, out_last_a, out_mask_a}, 32'd0);
    chk("rst_in_ready_b", {31'd0, in_ready_b}, 32'd1);
    $display("reset: in_ready=%0b out_valid=%0b busy=%0b", in_ready_a, out_valid_a, busy_a);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // First-beat latency: valid rises at the 2nd posedge after acceptance
    sa = qa.size(); sb = qb.size(); da = done_cnt_a; db = done_cnt_b;
    launch(vecs[0]);
    chk("lat_busy_after_accept", {31'd0, busy_a}, 32'd1);
    chk("lat_in_ready_after_accept", {31'd0, in_ready_a}, 32'd0);
    chk("lat_valid_edge0", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_edge1", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_edge2", {31'd0, out_valid_a}, 32'd1);
    chk("lat_beat_edge2", {11'd0, out_last_a, out_tile_x_a, out_tile_y_a, out_mask_a},
        {11'd0, vecs[0].e0[0]});
    wait_done(da, db);
    check_stream("lat", vecs[0], sa, sb);
    $display("latency: first beat valid two edges after accept");

    // Table-driven vectors
    for (int v = 0; v < 6; v++) run_vec(v);

    // Backpressure: consumer stalls 5 cycles with beats pending
    out_ready = 1'b0;
    sa = qa.size(); sb = qb.size(); da = done_cnt_a; db = done_cnt_b;
    launch(vecs[1]);
    k = 0;
    while (!out_valid_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_first_valid", {31'd0, out_valid_a}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid_a_%0d", c), {31'd0, out_valid_a}, 32'd1);
      chk($sformatf("bp_hold_beat_a_%0d", c),
          {11'd0, out_last_a, out_tile_x_a, out_tile_y_a, out_mask_a}, {11'd0, vecs[1].e0[0]});
      chk($sformatf("bp_hold_valid_b_%0d", c), {31'd0, out_valid_b}, 32'd1);
      chk($sformatf("bp_hold_beat_b_%0d", c),
          {11'd0, out_last_b, out_tile_x_b, out_tile_y_b, out_mask_b}, {11'd0, vecs[1].e1[0]});
    end
    out_ready = 1'b1;
    wait_done(da, db);
    check_stream("bp", vecs[1], sa, sb);
    $display("backpressure: beats noskip=%0d skip=%0d", qa.size() - sa, qb.size() - sb);

    // Reset in the middle of a scan
    launch(vecs[1]);
    k = 0;
    while (!out_valid_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mid_rst_scan_running", {31'd0, out_valid_a}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid_a", {31'd0, out_valid_a}, 32'd0);
    chk("mid_rst_in_ready_a", {31'd0, in_ready_a}, 32'd1);
    chk("mid_rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_out_valid_b", {31'd0, out_valid_b}, 32'd0);
    chk("mid_rst_in_ready_b", {31'd0, in_ready_b}, 32'd1);
    rst_n = 1'b1;
    na = qa.size(); nb = qb.size(); da = done_cnt_a; db = done_cnt_b;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_beats_a", qa.size() - na, 0);
    chk("mid_rst_no_beats_b", qb.size() - nb, 0);
    chk("mid_rst_no_done_a", done_cnt_a - da, 0);
    chk("mid_rst_no_done_b", done_cnt_b - db, 0);
    $display("mid-scan reset: out_valid=%0b in_ready=%0b", out_valid_a, in_ready_a);

    // Recovery after the abandoned triangle
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
